// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding, widths and
// the bundle of pipeline-register control outputs.
package hazard_pkg;

    localparam int REG_W = 5;

    localparam logic [1:0] RUN        = 2'd0;
    localparam logic [1:0] MEM_WAIT   = 2'd1;
    localparam logic [1:0] FLUSH_PEND = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN        = RUN,
        ST_MEM_WAIT   = MEM_WAIT,
        ST_FLUSH_PEND = FLUSH_PEND
    } state_t;

    typedef struct packed {
        logic pc_write;
        logic if_id_update;
        logic if_id_flush_n;
        logic id_ex_flush;
        logic ex_mem_flush;
        logic pipe_hold;
    } ctl_t;

    // Canned output patterns; if_id_flush_n is active low, so 1 means "keep".
    localparam ctl_t CTL_RESET  = ctl_t'(6'b000110);
    localparam ctl_t CTL_HOLD   = ctl_t'(6'b001001);
    localparam ctl_t CTL_FLUSH  = ctl_t'(6'b110110);
    localparam ctl_t CTL_STALL  = ctl_t'(6'b001100);
    localparam ctl_t CTL_NORMAL = ctl_t'(6'b111000);

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (inc_i && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt_o = r_cnt;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for a 5-stage MIPS pipe: load-use stalls, branch flushes and
// memory-wait holds, with saturating stall/flush event counters.
import hazard_pkg::*;

module pipeline_hazard_ctrl #(
    parameter int CNT_W = 16,
    parameter int REG_W = hazard_pkg::REG_W
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic             ex_memread_i,
    input  logic [REG_W-1:0] ex_rt_i,
    input  logic             branch_taken_i,
    input  logic             dmem_busy_i,
    output logic             pc_write_o,
    output logic             if_id_update_o,
    output logic             if_id_flush_n_o,
    output logic             id_ex_flush_o,
    output logic             ex_mem_flush_o,
    output logic             pipe_hold_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    state_t r_state;
    state_t w_state_next;
    logic   r_pend_flush;
    logic   w_pend_next;
    logic   w_load_use;
    logic   w_stall_inc;
    logic   w_flush_inc;
    ctl_t   w_ctl;
    ctl_t   w_out;

    // Register $zero is never really written, so a load into it cannot create a hazard.
    always_comb begin
        w_load_use = ex_memread_i & (ex_rt_i != '0) &
                     ((ex_rt_i == id_rs_i) | (id_uses_rt_i & (ex_rt_i == id_rt_i)));
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_RUN;
            r_pend_flush <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_pend_flush <= w_pend_next;
        end
    end

    always_comb begin
        w_ctl        = CTL_NORMAL;
        w_state_next = r_state;
        w_pend_next  = r_pend_flush;
        w_stall_inc  = 1'b0;
        w_flush_inc  = 1'b0;

        if (r_state == ST_FLUSH_PEND) begin
            if (dmem_busy_i) begin
                w_ctl        = CTL_HOLD;
                w_stall_inc  = 1'b1;
                w_pend_next  = 1'b1;
                w_state_next = ST_MEM_WAIT;
            end else begin
                w_ctl        = CTL_FLUSH;
                w_flush_inc  = 1'b1;
                w_pend_next  = 1'b0;
                w_state_next = ST_RUN;
            end
        end else if (dmem_busy_i) begin
            // A branch resolving while memory stalls is remembered and applied after release.
            w_ctl        = CTL_HOLD;
            w_stall_inc  = 1'b1;
            w_pend_next  = r_pend_flush | branch_taken_i;
            w_state_next = ST_MEM_WAIT;
        end else begin
            // RUN and the MEM_WAIT release cycle behave identically here.
            w_state_next = r_pend_flush ? ST_FLUSH_PEND : ST_RUN;
            if (branch_taken_i) begin
                w_ctl       = CTL_FLUSH;
                w_flush_inc = 1'b1;
            end else if (w_load_use) begin
                w_ctl       = CTL_STALL;
                w_stall_inc = 1'b1;
            end
        end
    end

    assign w_out           = rst_n ? w_ctl : CTL_RESET;
    assign pc_write_o      = w_out.pc_write;
    assign if_id_update_o  = w_out.if_id_update;
    assign if_id_flush_n_o = w_out.if_id_flush_n;
    assign id_ex_flush_o   = w_out.id_ex_flush;
    assign ex_mem_flush_o  = w_out.ex_mem_flush;
    assign pipe_hold_o     = w_out.pipe_hold;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .inc_i (w_stall_inc),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .inc_i (w_flush_inc),
        .cnt_o (flush_cnt_o)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus random traffic, checked
// against a cycle-level behavioural model; a 4-bit-counter instance checks saturation.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
    logic       id_uses_rt = 1'b0, ex_memread = 1'b0, branch_taken = 1'b0, dmem_busy = 1'b0;

    logic        a_pc, a_upd, a_fln, a_idex, a_exmem, a_hold;
    logic [15:0] a_stall, a_flush;
    logic        b_pc, b_upd, b_fln, b_idex, b_exmem, b_hold;
    logic [3:0]  b_stall, b_flush;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.CNT_W(16), .REG_W(5)) dut (
        .clk_i(clk), .rst_n(rst_n), .id_rs_i(id_rs), .id_rt_i(id_rt),
        .id_uses_rt_i(id_uses_rt), .ex_memread_i(ex_memread), .ex_rt_i(ex_rt),
        .branch_taken_i(branch_taken), .dmem_busy_i(dmem_busy),
        .pc_write_o(a_pc), .if_id_update_o(a_upd), .if_id_flush_n_o(a_fln),
        .id_ex_flush_o(a_idex), .ex_mem_flush_o(a_exmem), .pipe_hold_o(a_hold),
        .stall_cnt_o(a_stall), .flush_cnt_o(a_flush)
    );

    pipeline_hazard_ctrl #(.CNT_W(4), .REG_W(5)) dut4 (
        .clk_i(clk), .rst_n(rst_n), .id_rs_i(id_rs), .id_rt_i(id_rt),
        .id_uses_rt_i(id_uses_rt), .ex_memread_i(ex_memread), .ex_rt_i(ex_rt),
        .branch_taken_i(branch_taken), .dmem_busy_i(dmem_busy),
        .pc_write_o(b_pc), .if_id_update_o(b_upd), .if_id_flush_n_o(b_fln),
        .id_ex_flush_o(b_idex), .ex_mem_flush_o(b_exmem), .pipe_hold_o(b_hold),
        .stall_cnt_o(b_stall), .flush_cnt_o(b_flush)
    );

    wire [51:0] obs = {a_pc, a_upd, a_fln, a_idex, a_exmem, a_hold,
                       b_pc, b_upd, b_fln, b_idex, b_exmem, b_hold,
                       a_stall, a_flush, b_stall, b_flush};

    int n_cmp = 0;
    int n_bad = 0;

    // Model: mode 0 = flowing, 1 = waiting on memory, 2 = a deferred flush is owed.
    int m_mode = 0;
    bit m_pending = 1'b0;
    int m_s16 = 0, m_f16 = 0, m_s4 = 0, m_f4 = 0;
    logic [5:0]  exp_ctl;
    logic [51:0] exp_all;

    localparam logic [19:0] IDLE = 20'h80000;
    localparam logic [19:0] RST  = 20'h00000;

    function automatic logic [19:0] mk(logic rn, logic [4:0] rs, logic [4:0] rt, logic uses,
                                       logic mr, logic [4:0] xrt, logic br, logic busy);
        return {rn, rs, rt, uses, mr, xrt, br, busy};
    endfunction

    function automatic int sat(int v, int mx);
        return (v < mx) ? v + 1 : v;
    endfunction

    task automatic bump_stall();
        m_s16 = sat(m_s16, 65535);
        m_s4  = sat(m_s4, 15);
    endtask

    task automatic bump_flush();
        m_f16 = sat(m_f16, 65535);
        m_f4  = sat(m_f4, 15);
    endtask

    // Apply one cycle of stimulus at the falling edge and predict this cycle's outputs.
    task automatic drive(input logic [19:0] v);
        logic rn, uses, mr, br, busy;
        logic [4:0] rs, rt, xrt;
        logic [15:0] s16, f16;
        logic [3:0] s4, f4;
        bit lu;
        {rn, rs, rt, uses, mr, xrt, br, busy} = v;
        @(negedge clk);
        rst_n = rn; id_rs = rs; id_rt = rt; id_uses_rt = uses;
        ex_memread = mr; ex_rt = xrt; branch_taken = br; dmem_busy = busy;
        #1;
        if (!rn) begin
            m_mode = 0; m_pending = 1'b0;
            m_s16 = 0; m_f16 = 0; m_s4 = 0; m_f4 = 0;
        end
        s16 = m_s16[15:0]; f16 = m_f16[15:0]; s4 = m_s4[3:0]; f4 = m_f4[3:0];
        exp_ctl = 6'b000110;
        if (rn) begin
            lu = mr && (xrt != 0) && ((xrt == rs) || (uses && (xrt == rt)));
            if (m_mode == 2) begin
                if (busy) begin
                    exp_ctl = 6'b001001; bump_stall(); m_mode = 1;
                end else begin
                    exp_ctl = 6'b110110; bump_flush(); m_pending = 1'b0; m_mode = 0;
                end
            end else if (busy) begin
                exp_ctl = 6'b001001; bump_stall(); m_mode = 1;
                if (br) m_pending = 1'b1;
            end else begin
                if (br) begin
                    exp_ctl = 6'b110110; bump_flush();
                end else if (lu) begin
                    exp_ctl = 6'b001100; bump_stall();
                end else begin
                    exp_ctl = 6'b111000;
                end
                m_mode = m_pending ? 2 : 0;
            end
        end
        exp_all = {exp_ctl, exp_ctl, s16, f16, s4, f4};
    endtask

    task automatic test_reset();
        logic [19:0] seq[$];
        seq.push_back(RST); seq.push_back(RST); seq.push_back(IDLE); seq.push_back(IDLE);
        foreach (seq[i]) begin
            drive(seq[i]);
            n_cmp++;
            if (obs !== exp_all) begin
                n_bad++;
                $display("FAIL reset[%0d]: got %h want %h", i, obs, exp_all);
            end
        end
    endtask

    task automatic test_load_use();
        logic [19:0] seq[$];
        seq.push_back(RST);
        seq.push_back(mk(1, 5'd2, 5'd3, 1, 1, 5'd2, 0, 0));
        seq.push_back(mk(1, 5'd2, 5'd3, 1, 0, 5'd9, 0, 0));
        seq.push_back(mk(1, 5'd4, 5'd5, 0, 1, 5'd5, 0, 0));
        seq.push_back(IDLE);
        foreach (seq[i]) begin
            drive(seq[i]);
            n_cmp++;
            if (obs !== exp_all) begin
                n_bad++;
                $display("FAIL load_use[%0d]: got %h want %h", i, obs, exp_all);
            end
        end
        n_cmp++;
        if (a_stall !== 16'd1) begin
            n_bad++;
            $display("FAIL load_use_stall_cnt: got %0d want 1", a_stall);
        end
    endtask

    task automatic test_zero_reg();
        logic [19:0] seq[$];
        seq.push_back(RST);
        for (int k = 0; k < 4; k++) seq.push_back(mk(1, 5'd0, 5'd0, 1, 1, 5'd0, 0, 0));
        seq.push_back(IDLE);
        foreach (seq[i]) begin
            drive(seq[i]);
            n_cmp++;
            if (obs !== exp_all || (i > 0 && a_pc !== 1'b1)) begin
                n_bad++;
                $display("FAIL zero_reg[%0d]: got %h want %h", i, obs, exp_all);
            end
        end
        n_cmp++;
        if (a_stall !== 16'd0) begin
            n_bad++;
            $display("FAIL zero_reg_stall_cnt: got %0d want 0", a_stall);
        end
    endtask

    task automatic test_branch_over_load_use();
        logic [19:0] seq[$];
        seq.push_back(RST);
        seq.push_back(mk(1, 5'd6, 5'd1, 1, 1, 5'd6, 1, 0));
        seq.push_back(IDLE);
        foreach (seq[i]) begin
            drive(seq[i]);
            n_cmp++;
            if (obs !== exp_all) begin
                n_bad++;
                $display("FAIL branch_lu[%0d]: got %h want %h", i, obs, exp_all);
            end
        end
        n_cmp++;
        if (a_flush !== 16'd1 || a_stall !== 16'd0) begin
            n_bad++;
            $display("FAIL branch_lu_counts: got flush=%0d stall=%0d want 1/0", a_flush, a_stall);
        end
    endtask

    task automatic test_mem_wait_flush();
        logic [19:0] seq[$];
        seq.push_back(RST);
        seq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1));
        seq.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1));
        seq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1));
        seq.push_back(IDLE);
        seq.push_back(IDLE);
        seq.push_back(IDLE);
        foreach (seq[i]) begin
            drive(seq[i]);
            n_cmp++;
            if (obs !== exp_all) begin
                n_bad++;
                $display("FAIL mem_wait[%0d]: got %h want %h", i, obs, exp_all);
            end
        end
        n_cmp++;
        if (a_stall !== 16'd3 || a_flush !== 16'd1) begin
            n_bad++;
            $display("FAIL mem_wait_counts: got stall=%0d flush=%0d want 3/1", a_stall, a_flush);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [19:0] seq[$];
        seq.push_back(RST);
        seq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1));
        seq.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1));
        seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
        seq.push_back(RST);
        for (int k = 0; k < 3; k++) seq.push_back(IDLE);
        foreach (seq[i]) begin
            drive(seq[i]);
            n_cmp++;
            if (obs !== exp_all) begin
                n_bad++;
                $display("FAIL reset_mid_wait[%0d]: got %h want %h", i, obs, exp_all);
            end
        end
        n_cmp++;
        if (a_flush !== 16'd0 || a_stall !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_mid_wait_counts: got flush=%0d stall=%0d want 0/0", a_flush, a_stall);
        end
    endtask

    task automatic test_saturation();
        logic [19:0] seq[$];
        seq.push_back(RST);
        for (int k = 0; k < 20; k++) seq.push_back(mk(1, 5'd7, 5'd0, 0, 1, 5'd7, 0, 0));
        foreach (seq[i]) begin
            drive(seq[i]);
            n_cmp++;
            if (obs !== exp_all) begin
                n_bad++;
                $display("FAIL saturation[%0d]: got %h want %h", i, obs, exp_all);
            end
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (b_stall !== 4'hF || a_stall !== 16'd20) begin
            n_bad++;
            $display("FAIL saturation_counts: got cnt4=%h cnt16=%0d want F/20", b_stall, a_stall);
        end
    endtask

    task automatic test_random();
        logic [19:0] v;
        drive(RST);
        for (int i = 0; i < 400; i++) begin
            v = mk(($urandom_range(0, 59) != 0),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                   5'($urandom_range(0, 3)),
                   ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0));
            drive(v);
            n_cmp++;
            if (obs !== exp_all) begin
                n_bad++;
                $display("FAIL random[%0d]: stim %h got %h want %h", i, v, obs, exp_all);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_use();
        test_zero_reg();
        test_branch_over_load_use();
        test_mem_wait_flush();
        test_reset_mid_wait();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
